// File: rtl/k12a_lcd_pkg.sv
// k12a_lcd_pkg
//   Shared definitions for the k12a character-LCD write sequencer:
//   controller state encoding, HD44780 command bytes, the power-up
//   initialisation ROM and small helper functions.
package k12a_lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_HOME         = 8'h02;
  localparam logic [7:0] LCD_FUNCSET_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;

  localparam int INIT_LEN = 4;

  // Sent in order after power-up: 8-bit/2-line, display on, clear, entry mode.
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    LCD_FUNCSET_8B2L, LCD_DISP_ON, LCD_CLEAR, LCD_ENTRY_INC
  };

  // Clear and home are the only instructions with a long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/k12a_lcd_timer.sv
// k12a_lcd_timer
//   Loadable down-counter that saturates at zero.
//   Ports:
//     clk_i    clock
//     rst_i    asynchronous active-high reset (counter returns to RST_VAL)
//     load_i   load value_i this cycle (takes priority over counting)
//     value_i  value to load
//     zero_o   counter currently holds zero
module k12a_lcd_timer #(
  parameter int             W       = 20,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/k12a_lcd_controller.sv
// k12a_lcd_controller
//   Drives an HD44780-style character LCD. After reset it waits out the
//   panel power-up time, sends the four-entry init sequence, then accepts
//   instruction/data byte writes over a valid/ready handshake. Every write
//   gets a setup / enable-pulse / hold cycle followed by the LCD execution
//   wait before the next write is accepted.
//   Ports:
//     cpu_clock  system clock
//     reset      asynchronous active-high reset
//     req_valid  requester has a write pending
//     req_ready  write accepted this cycle (only in IDLE)
//     req_rs     0 = instruction, 1 = data
//     req_data   byte to write
//     lcd_rs     LCD register select (registered)
//     lcd_rw     always 0, write only
//     lcd_en     LCD enable strobe
//     lcd_data   LCD data bus (registered)
//     busy       controller not idle
//     init_done  sticky, set once the init sequence has completed
module k12a_lcd_controller
  import k12a_lcd_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int EXEC_CYCLES    = 2000,
  parameter int CLEAR_CYCLES   = 80000,
  parameter int POWERUP_CYCLES = 800000
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       init_done
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYCLES, PULSE_CYCLES),
                                           max_int(HOLD_CYCLES, EXEC_CYCLES)),
                                   max_int(CLEAR_CYCLES, POWERUP_CYCLES));
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Every phase lasting N cycles loads N-1 on entry and leaves when the timer hits zero.
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXEC_LD    = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD   = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] POWERUP_LD = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [1:0]       LAST_IDX   = 2'(INIT_LEN - 1);

  lcd_state_e       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  // The timer comes out of reset already holding the power-up count,
  // so POWERUP needs no entry load.
  k12a_lcd_timer #(
    .W       (CNT_W),
    .RST_VAL (POWERUP_LD)
  ) u_timer (
    .clk_i   (cpu_clock),
    .rst_i   (reset),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    unique case (state_q)
      ST_POWERUP: begin
        if (tmr_zero) state_d = ST_INIT;
      end
      ST_INIT: begin
        rs_d     = 1'b0;
        data_d   = INIT_ROM[idx_q];
        state_d  = ST_SETUP;
        tmr_load = 1'b1;
        tmr_val  = SETUP_LD;
      end
      ST_IDLE: begin
        if (req_valid) begin
          rs_d     = req_rs;
          data_d   = req_data;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d  = ST_EXEC;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, data_q) ? CLEAR_LD : EXEC_LD;
        end
      end
      ST_EXEC: begin
        if (tmr_zero) begin
          if (!init_done_q && (idx_q != LAST_IDX)) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_INIT;
          end else begin
            // Index parks at the last entry, so this re-asserts harmlessly later.
            if (idx_q == LAST_IDX) init_done_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_POWERUP;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  // Enable decodes straight from the state register so reset kills it at once.
  assign lcd_en    = (state_q == ST_PULSE);
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = rs_q;
  assign lcd_data  = data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_k12a_lcd_controller.sv
module tb_k12a_lcd_controller;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int E  = 3;
  localparam int C  = 6;
  localparam int PU = 10;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs    = 1'b0;
  logic [7:0] req_data  = 8'h00;
  logic       req_ready;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       busy;
  logic       init_done;

  always #5 clk = ~clk;

  k12a_lcd_controller #(
    .SETUP_CYCLES   (S),
    .PULSE_CYCLES   (P),
    .HOLD_CYCLES    (H),
    .EXEC_CYCLES    (E),
    .CLEAR_CYCLES   (C),
    .POWERUP_CYCLES (PU)
  ) dut (
    .cpu_clock (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data),
    .busy      (busy),
    .init_done (init_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a write launched at edge L drives EN for edges
  // L+S .. L+S+P-1 and the bus is free again from edge L+S+P+H+W on.
  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         m_t, m_idx, m_next, m_launch, m_end;
  bit         m_have, m_done, m_ready, m_prev;
  logic       m_rs;
  logic [7:0] m_data;

  int         en_rise_t[$];
  logic [7:0] en_rise_d[$];
  int         first_ready_t = -1;
  logic       en_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, m_t, act, exp);
    end
  endtask

  task automatic launch(input logic rs, input logic [7:0] d);
    int w;
    w        = (!rs && (d == 8'h01 || d == 8'h02)) ? C : E;
    m_have   = 1'b1;
    m_launch = m_t;
    m_rs     = rs;
    m_data   = d;
    m_end    = m_t + S + P + H + w;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_t = 0; m_idx = 0; m_next = PU + 1; m_launch = 0; m_end = 0;
      m_have = 1'b0; m_done = 1'b0; m_ready = 1'b0;
      m_rs = 1'b0; m_data = 8'h00;
    end else begin
      m_prev = m_ready;
      m_t++;
      if (!m_done && m_t == m_next) launch(1'b0, rom[m_idx]);
      else if (m_done && m_prev && req_valid) launch(req_rs, req_data);
      if (m_have && !m_done && m_t == m_end) begin
        if (m_idx < 3) begin
          m_idx++;
          m_next = m_t + 1;
        end else begin
          m_done = 1'b1;
        end
      end
      m_ready = m_done && (m_t >= m_end);
    end
  end

  // Per-cycle comparison against the model, plus event capture for literal checks.
  initial forever begin
    logic exp_en;
    @(negedge clk);
    exp_en = m_have && (m_t >= m_launch + S) && (m_t <= m_launch + S + P - 1);
    chk("ready",     {31'd0, req_ready}, {31'd0, m_ready});
    chk("busy",      {31'd0, busy},      {31'd0, !m_ready});
    chk("en",        {31'd0, lcd_en},    {31'd0, exp_en});
    chk("rs",        {31'd0, lcd_rs},    {31'd0, m_rs});
    chk("data",      {24'd0, lcd_data},  {24'd0, m_data});
    chk("init_done", {31'd0, init_done}, {31'd0, m_done});
    chk("rw",        {31'd0, lcd_rw},    32'd0);
    if (reset) begin
      en_rise_t.delete();
      en_rise_d.delete();
      first_ready_t = -1;
      en_prev = 1'b0;
    end else begin
      if (lcd_en && !en_prev) begin
        en_rise_t.push_back(m_t);
        en_rise_d.push_back(lcd_data);
      end
      en_prev = lcd_en;
      if (req_ready && first_ready_t < 0) first_ready_t = m_t;
    end
  end

  // Present a write and hold it until accepted; returns the accepting edge.
  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    int budget;
    budget    = 0;
    acc       = -1;
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    acc = m_t;
  endtask

  int a [6];
  int an;
  int b;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd1);
    chk("rst_en",    {31'd0, lcd_en},    32'd0);
    chk("rst_data",  {24'd0, lcd_data},  32'd0);
    chk("rst_done",  {31'd0, init_done}, 32'd0);

    // Request is already pending while init runs.
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
    reset = 1'b0;
    send(1'b1, 8'h41, a[0]);
    send(1'b1, 8'h42, a[1]);
    send(1'b1, 8'h43, a[2]);
    send(1'b0, 8'h01, a[3]);
    send(1'b0, 8'h80, a[4]);
    send(1'b1, 8'h5A, a[5]);
    req_valid = 1'b0;
    chk("acc_first_0x41",    a[0], 32'd46);
    chk("acc_b2b_0x42",      a[1], 32'd54);
    chk("acc_b2b_0x43",      a[2], 32'd62);
    chk("acc_0x01",          a[3], 32'd70);
    chk("acc_after_clear",   a[4], 32'd81);
    chk("acc_after_0x80",    a[5], 32'd89);
    chk("first_ready_t",     first_ready_t, 32'd45);
    chk("init_pulses_ge4",   {31'd0, en_rise_t.size() >= 4}, 32'd1);
    if (en_rise_t.size() >= 4) begin
      chk("en_rise0", en_rise_t[0], 32'd12);
      chk("en_rise1", en_rise_t[1], 32'd20);
      chk("en_rise2", en_rise_t[2], 32'd28);
      chk("en_rise3", en_rise_t[3], 32'd39);
      chk("init_d0", {24'd0, en_rise_d[0]}, 32'h38);
      chk("init_d1", {24'd0, en_rise_d[1]}, 32'h0C);
      chk("init_d2", {24'd0, en_rise_d[2]}, 32'h01);
      chk("init_d3", {24'd0, en_rise_d[3]}, 32'h06);
    end

    for (int i = 0; i < 40; i++) begin
      int         gap;
      int         r;
      logic [7:0] d;
      gap = $urandom_range(0, 3);
      req_valid = 1'b0;
      req_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
      r = $urandom_range(0, 7);
      d = (r == 0) ? 8'h01 : (r == 1) ? 8'h02 : 8'($urandom);
      send(1'($urandom_range(0, 1)), d, an);
    end
    req_valid = 1'b0;

    // Reset in the middle of an enable pulse.
    @(negedge clk);
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
    b = 0;
    while (!lcd_en && b < 100) begin
      @(negedge clk);
      b++;
    end
    req_valid = 1'b0;
    chk("pulse_seen", {31'd0, lcd_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_en",    {31'd0, lcd_en},    32'd0);
    chk("mid_rst_busy",  {31'd0, busy},      32'd1);
    chk("mid_rst_done",  {31'd0, init_done}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    b = 0;
    while (!init_done && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("reinit_done_t",     m_t, 32'd45);
    chk("reinit_first_rdy",  first_ready_t, 32'd45);
    send(1'b0, 8'h02, an);
    req_valid = 1'b0;
    chk("reinit_acc", an, 32'd46);
    repeat (14) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
